chkrpl_pipe: RTL and testbench

CHKRPL_PIPE -- requirements
Module: chkrpl_pipe

---
 rtl/chkrpl_pkg.sv | 13 +
 rtl/chkrpl_stage.sv | 37 +++
 rtl/chkrpl_pipe.sv | 102 ++++++++++
 tb/tb_chkrpl_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chkrpl_pkg.sv
// Shared defaults and helpers for the chkrpl valid/ready pipeline.
package chkrpl_pkg;

    localparam int          DEF_WIDTH     = 4;
    localparam int          DEF_DEPTH     = 3;
    localparam logic [63:0] DEF_RESET_VAL = 64'd10;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/chkrpl_stage.sv
// One pipeline stage: a valid bit and a data register with ready passed upstream.
module chkrpl_stage
    import chkrpl_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = DEF_RESET_VAL[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    assign ready = ~valid | down_ready;

    // A ready stage with no incoming word becomes empty but keeps its old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/chkrpl_pipe.sv
// DEPTH-stage valid/ready pipeline with registered occupancy count and flush.
module chkrpl_pipe
    import chkrpl_pkg::*;
#(
    parameter int          WIDTH     = DEF_WIDTH,
    parameter int          DEPTH     = DEF_DEPTH,
    parameter logic [63:0] RESET_VAL = DEF_RESET_VAL
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             d_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             d_out,
    output logic [occ_width(DEPTH)-1:0]  occupancy,
    input  logic                         test_mode,
    input  logic                         scan_en,
    input  logic                         scan_in0,
    output logic                         scan_out0
);

    localparam int               OCC_W    = occ_width(DEPTH);
    localparam logic [WIDTH-1:0] RST_DATA = RESET_VAL[WIDTH-1:0];

    logic run_en;
    logic in_hs;
    logic out_hs;
    logic dft_unused;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             down_ready;
        logic             ready;
        logic             valid;
        logic [WIDTH-1:0] data;

        if (i == 0) begin : g_first
            assign up_valid = in_valid & run_en;
            assign up_data  = d_in;
        end else begin : g_next
            assign up_valid = g_stage[i-1].valid;
            assign up_data  = g_stage[i-1].data;
        end

        if (i == DEPTH - 1) begin : g_last
            assign down_ready = out_ready;
        end else begin : g_inner
            assign down_ready = g_stage[i+1].ready;
        end

        chkrpl_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RST_DATA)
        ) u_stage (
            .clk        (clk),
            .reset_n    (reset_n),
            .flush      (flush),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .down_ready (down_ready),
            .ready      (ready),
            .valid      (valid),
            .data       (data)
        );
    end

    // Holds in_ready low during reset and until the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    assign in_ready  = run_en & g_stage[0].ready & ~flush;
    assign out_valid = g_stage[DEPTH-1].valid;
    assign d_out     = g_stage[DEPTH-1].data;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_hs && !out_hs) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (out_hs && !in_hs) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

    assign dft_unused = test_mode ^ scan_en ^ scan_in0;
    assign scan_out0  = 1'b0;

endmodule

// File: tb/tb_chkrpl_pipe.sv
// Directed and randomized checks of chkrpl_pipe at three parameter points.
module tb_chkrpl_pipe;

    localparam int W  = 4;
    localparam int D  = 3;
    localparam int OW = $clog2(D + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, flush, in_valid, in_ready, out_valid, out_ready, scan_out0;
    logic [W-1:0]  d_in, d_out;
    logic [OW-1:0] occupancy;

    logic        sreset_n;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_scan_out0;
    logic [0:0]  a_d_in, a_d_out, a_occ;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_scan_out0;
    logic [63:0] b_d_in, b_d_out;
    logic [4:0]  b_occ;

    int n_compared;
    int n_mismatch;

    logic [W-1:0] delivered[$];
    int           expected_q[$];

    chkrpl_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(64'd10)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
        .occupancy(occupancy), .test_mode(1'b0), .scan_en(1'b0), .scan_in0(1'b0),
        .scan_out0(scan_out0)
    );

    chkrpl_pipe #(.WIDTH(1), .DEPTH(1)) dut_a (
        .clk(clk), .reset_n(sreset_n), .flush(1'b0), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .d_in(a_d_in), .out_valid(a_out_valid), .out_ready(a_out_ready), .d_out(a_d_out),
        .occupancy(a_occ), .test_mode(1'b0), .scan_en(1'b0), .scan_in0(1'b0),
        .scan_out0(a_scan_out0)
    );

    chkrpl_pipe #(.WIDTH(64), .DEPTH(16)) dut_b (
        .clk(clk), .reset_n(sreset_n), .flush(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .d_in(b_d_in), .out_valid(b_out_valid), .out_ready(b_out_ready), .d_out(b_d_out),
        .occupancy(b_occ), .test_mode(1'b0), .scan_en(1'b0), .scan_in0(1'b0),
        .scan_out0(b_scan_out0)
    );

    // Records every word the main DUT hands downstream.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            delivered.push_back(d_out);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic f,
                                 input logic ordy);
        in_valid  = v;
        d_in      = d;
        flush     = f;
        out_ready = ordy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkDelivered(input string tag);
        checkOutput({tag, "_count"}, 64'(delivered.size()), 64'(expected_q.size()));
        for (int i = 0; i < delivered.size() && i < expected_q.size(); i++) begin
            checkOutput({tag, "_word"}, 64'(delivered[i]), 64'(expected_q[i]));
        end
    endtask

    initial begin
        int          j;
        logic        exp_valid;
        int          exp_in;
        int          exp_out;
        int          qa[$];
        logic [63:0] qb[$];

        n_compared = 0;
        n_mismatch = 0;
        reset_n    = 1'b0;
        sreset_n   = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_d_in = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_d_in = '0;

        // Reset values, and in_ready held low until the first edge after release.
        tick;
        checkOutput("rst_d_out", 64'(d_out), 64'd10);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        reset_n  = 1'b1;
        sreset_n = 1'b1;
        #1;
        checkOutput("release_in_ready_pre_edge", 64'(in_ready), 64'd0);
        tick;
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("scan_out0", 64'(scan_out0), 64'd0);

        // Streaming 1..5 with out_ready high: valid three edges after acceptance.
        delivered.delete();
        for (int k = 0; k < 9; k++) begin
            applyStimulus(k < 5, W'(k + 1), 1'b0, 1'b1);
            #1;
            if (k < 5) checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
            tick;
            j         = k + 1;
            exp_valid = (j >= 3 && j <= 7);
            checkOutput("stream_out_valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid) checkOutput("stream_d_out", 64'(d_out), 64'(j - 2));
            exp_in  = (j < 5) ? j : 5;
            exp_out = (j <= 3) ? 0 : ((j - 3 > 5) ? 5 : j - 3);
            checkOutput("stream_occupancy", 64'(occupancy), 64'(exp_in - exp_out));
        end
        expected_q = '{1, 2, 3, 4, 5};
        checkDelivered("stream_order");

        // Backpressure: three words fill the pipe, the fourth waits.
        delivered.delete();
        expected_q = '{7, 8, 9};
        foreach (expected_q[i]) begin
            applyStimulus(1'b1, W'(expected_q[i]), 1'b0, 1'b0);
            #1;
            checkOutput("bp_in_ready_fill", 64'(in_ready), 64'd1);
            tick;
        end
        checkOutput("bp_occupancy_full", 64'(occupancy), 64'd3);
        checkOutput("bp_d_out_head", 64'(d_out), 64'd7);
        applyStimulus(1'b1, W'(11), 1'b0, 1'b0);
        #1;
        checkOutput("bp_in_ready_full", 64'(in_ready), 64'd0);
        tick;
        checkOutput("bp_occupancy_hold", 64'(occupancy), 64'd3);
        applyStimulus(1'b1, W'(11), 1'b0, 1'b1);
        #1;
        checkOutput("bp_in_ready_release", 64'(in_ready), 64'd1);
        tick;
        checkOutput("bp_occupancy_swap", 64'(occupancy), 64'd3);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (4) tick;
        checkOutput("bp_occupancy_drained", 64'(occupancy), 64'd0);
        expected_q = '{7, 8, 9, 11};
        checkDelivered("bp_order");

        // Flush with two words in flight and an input offered alongside it.
        delivered.delete();
        applyStimulus(1'b1, W'(1), 1'b0, 1'b0);
        tick;
        applyStimulus(1'b1, W'(2), 1'b0, 1'b0);
        tick;
        checkOutput("flush_pre_occupancy", 64'(occupancy), 64'd2);
        applyStimulus(1'b1, W'(5), 1'b1, 1'b0);
        #1;
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        tick;
        checkOutput("flush_occupancy", 64'(occupancy), 64'd0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_d_out", 64'(d_out), 64'd10);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (4) tick;
        expected_q.delete();
        checkDelivered("flush_nothing_out");

        // A word leaving in the flush cycle still counts as delivered.
        delivered.delete();
        for (int k = 12; k <= 14; k++) begin
            applyStimulus(1'b1, W'(k), 1'b0, 1'b0);
            tick;
        end
        checkOutput("flush_hs_d_out", 64'(d_out), 64'd12);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        tick;
        checkOutput("flush_hs_occupancy", 64'(occupancy), 64'd0);
        checkOutput("flush_hs_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (3) tick;
        expected_q = '{12};
        checkDelivered("flush_hs_delivered");

        // Asynchronous reset with three words in flight discards all of them.
        delivered.delete();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, W'(k), 1'b0, 1'b1);
            tick;
        end
        checkOutput("midrst_pre_occupancy", 64'(occupancy), 64'd3);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_d_out", 64'(d_out), 64'd10);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        #1;
        reset_n = 1'b1;
        #1;
        checkOutput("midrst_in_ready_pre_edge", 64'(in_ready), 64'd0);
        tick;
        checkOutput("midrst_in_ready_release", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, W'(6), 1'b0, 1'b1);
        tick;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("midrst_lat1_out_valid", 64'(out_valid), 64'd0);
        tick;
        checkOutput("midrst_lat2_out_valid", 64'(out_valid), 64'd0);
        tick;
        checkOutput("midrst_lat3_out_valid", 64'(out_valid), 64'd1);
        checkOutput("midrst_lat3_d_out", 64'(d_out), 64'd6);
        tick;
        expected_q = '{6};
        checkDelivered("midrst_delivered");

        // Random valid/ready on the extreme configurations against FIFO models.
        for (int c = 0; c < 500; c++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_out_ready = 1'($urandom_range(0, 1));
            a_d_in      = 1'($urandom_range(0, 1));
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = 1'($urandom_range(0, 1));
            b_d_in      = {$urandom, $urandom};
            #1;
            if (qa.size() == 1 && !a_out_ready) begin
                checkOutput("swA_full_in_ready", 64'(a_in_ready), 64'd0);
            end
            if (qb.size() == 16 && !b_out_ready) begin
                checkOutput("swB_full_in_ready", 64'(b_in_ready), 64'd0);
            end
            if (a_out_valid && a_out_ready) begin
                checkOutput("swA_nonempty", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) begin
                    checkOutput("swA_order", 64'(a_d_out), 64'(qa.pop_front()));
                end
            end
            if (b_out_valid && b_out_ready) begin
                checkOutput("swB_nonempty", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) begin
                    checkOutput("swB_order", b_d_out, qb.pop_front());
                end
            end
            if (a_in_valid && a_in_ready) qa.push_back(int'(a_d_in));
            if (b_in_valid && b_in_ready) qb.push_back(b_d_in);
            tick;
            checkOutput("swA_occupancy", 64'(a_occ), 64'(qa.size()));
            checkOutput("swB_occupancy", 64'(b_occ), 64'(qb.size()));
        end
        checkOutput("swA_scan_out0", 64'(a_scan_out0), 64'd0);
        checkOutput("swB_scan_out0", 64'(b_scan_out0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
